pts_tx_sequencer: RTL



---
 rtl/pts_tx_pkg.sv | 35 +++
 rtl/pts_tx_sequencer_bit_timer.sv | 42 ++++
 rtl/pts_tx_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/pts_tx_pkg.sv
// Shared types and frame-layout helper for the parallel-to-serial transmit sequencer.
package pts_tx_pkg;

  localparam int unsigned MAX_DATA_BITS  = 16;
  localparam int unsigned MAX_FRAME_BITS = 20;
  localparam int unsigned FRAME_IDX_W    = 5;
  localparam int unsigned DATA_IDX_W     = 4;

  typedef enum logic {IDLE, SEND} tx_state_t;

  typedef logic [MAX_FRAME_BITS-1:0] frame_word_t;

  // Start bit at the top, data LSB-first below it, optional even parity, stop bits at the bottom.
  // Only the low 1+data_bits+parity_en+stop_bits bits of the result are meaningful.
  function automatic frame_word_t build_frame(
    input logic [MAX_DATA_BITS-1:0] data,
    input int unsigned              data_bits,
    input int unsigned              parity_en,
    input int unsigned              stop_bits
  );
    frame_word_t f;
    int unsigned fb;
    fb = 1 + data_bits + parity_en + stop_bits;
    f  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (i < stop_bits) f[FRAME_IDX_W'(i)] = 1'b1;
    end
    if (parity_en != 0) f[FRAME_IDX_W'(stop_bits)] = ^data;
    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < data_bits) f[FRAME_IDX_W'(fb - 2 - i)] = data[DATA_IDX_W'(i)];
    end
    return f;
  endfunction

endpackage

// File: rtl/pts_tx_sequencer_bit_timer.sv
// Clocks-per-bit counter with synchronous clear and a registered rollover flag.
module tx_bit_timer
  import pts_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic rollover_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rollover_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Flag is precomputed from the next count so it is high exactly while cnt_q == CNT_MAX.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q      <= '0;
      rollover_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rollover_q <= (cnt_d == CNT_MAX);
    end
  end

  assign rollover_o = rollover_q;

endmodule

// File: rtl/pts_tx_sequencer.sv
// Frame-level controller driving load/shift of an MSB-first parallel-to-serial shift register.
module pts_tx_sequencer
  import pts_tx_pkg::*;
#(
  parameter  int unsigned DATA_BITS    = 8,
  parameter  int unsigned CLKS_PER_BIT = 10,
  parameter  int unsigned PARITY_EN    = 0,
  parameter  int unsigned STOP_BITS    = 1,
  localparam int unsigned FRAME_BITS   = 1 + DATA_BITS + PARITY_EN + STOP_BITS
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tx_valid,
  input  logic [DATA_BITS-1:0]  tx_data,
  output logic                  tx_ready,
  output logic                  load_enable,
  output logic                  shift_enable,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BIT_W = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  tx_state_t        state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             rollover;
  frame_word_t      frame_full;
  logic             unused_frame_hi;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (load_enable),
    .enable_i  (tx_busy),
    .rollover_o(rollover)
  );

  assign frame_full      = build_frame(MAX_DATA_BITS'(tx_data), DATA_BITS, PARITY_EN, STOP_BITS);
  assign frame_out       = frame_full[FRAME_BITS-1:0];
  assign unused_frame_hi = ^(frame_full >> FRAME_BITS);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next state and Mealy handshake/strobe outputs; a load in the final cycle chains frames.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tx_ready     = 1'b0;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    tx_busy      = 1'b0;
    tx_done      = 1'b0;
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
      end
      SEND: begin
        tx_busy = 1'b1;
        if (rollover) begin
          if (bit_cnt_q == BIT_LAST) begin
            tx_done   = 1'b1;
            tx_ready  = 1'b1;
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            shift_enable = 1'b1;
            bit_cnt_d    = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
    load_enable = tx_valid && tx_ready;
    if (load_enable) begin
      state_d   = SEND;
      bit_cnt_d = '0;
    end
  end

endmodule
